// File: rtl/mul_issue_queue_if.sv
// Dispatch-side and unit-side buses of the multiply/divide issue queue.
// The queue uses the slave view; dispatch and the unit together form the master view.
interface mul_issue_queue_if #(
  parameter int CNTRL_SIZE = 7,
  parameter int RV         = 64,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int LNCOMMIT   = 5
);
  localparam int HW = (NHART == 1) ? 1 : LNHART;

  logic                  in_valid;
  logic                  in_ready;
  logic [CNTRL_SIZE-1:0] in_control;
  logic [LNCOMMIT-1:0]   in_rd;
  logic                  in_makes_rd;
  logic [RV-1:0]         in_r1;
  logic [RV-1:0]         in_r2;
  logic [HW-1:0]         in_hart;

  logic                  divide_busy;
  logic                  enable;
  logic [CNTRL_SIZE-1:0] control;
  logic [LNCOMMIT-1:0]   rd;
  logic                  makes_rd;
  logic [HW-1:0]         hart;
  logic [RV-1:0]         r1;
  logic [RV-1:0]         r2;

  modport master (
    output in_valid, in_control, in_rd, in_makes_rd, in_r1, in_r2, in_hart, divide_busy,
    input  in_ready, enable, control, rd, makes_rd, hart, r1, r2
  );

  modport slave (
    input  in_valid, in_control, in_rd, in_makes_rd, in_r1, in_r2, in_hart, divide_busy,
    output in_ready, enable, control, rd, makes_rd, hart, r1, r2
  );
endinterface

// File: rtl/mul_issue_queue.sv
// In-order issue queue in front of the multiply/divide unit; serialises divides and drops killed ops.
// Optional same-cycle bypass into an empty queue is enabled by defining MULQ_BYPASS_EN.
module mul_issue_queue #(
  parameter int CNTRL_SIZE = 7,
  parameter int RV         = 64,
  parameter int NHART      = 1,
  parameter int LNHART     = 0,
  parameter int NCOMMIT    = 32,
  parameter int LNCOMMIT   = 5,
  parameter int DEPTH      = 4,
  parameter int LNDEPTH    = 2
) (
  input  logic                clk,
  input  logic                reset,
  mul_issue_queue_if.slave    bus,
  input  logic [NCOMMIT-1:0]  commit_kill_0,
  output logic                empty
);
  localparam int HW = (NHART == 1) ? 1 : LNHART;

  typedef struct packed {
    logic [CNTRL_SIZE-1:0] control;
    logic [LNCOMMIT-1:0]   rd;
    logic                  makes_rd;
    logic [HW-1:0]         hart;
    logic [RV-1:0]         r1;
    logic [RV-1:0]         r2;
  } op_t;

  op_t                ops [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [DEPTH-1:0]   dead;
  logic [LNDEPTH-1:0] head;
  logic [LNDEPTH-1:0] tail;
  logic [LNDEPTH:0]   count;
  logic               div_hold;
  logic [RV-1:0]      r1_q;
  logic [RV-1:0]      r2_q;

  op_t  in_op;
  op_t  head_op;
  op_t  issue_op;
  logic head_valid;
  logic head_killed;
  logic head_div;
  logic div_free;
  logic head_ok;
  logic bypass;
  logic issue;
  logic pop;
  logic push;
  logic ready;

  assign in_op = '{control:  bus.in_control,
                   rd:       bus.in_rd,
                   makes_rd: bus.in_makes_rd,
                   hart:     bus.in_hart,
                   r1:       bus.in_r1,
                   r2:       bus.in_r2};

  assign head_op     = ops[head];
  assign head_valid  = valid[head];
  assign head_killed = dead[head] | commit_kill_0[head_op.rd];
  assign head_div    = !head_op.control[5] && !head_op.control[0];
  // div_hold covers the cycle between a divide issuing and divide_busy rising.
  assign div_free    = !bus.divide_busy && !div_hold;
  assign head_ok     = head_valid && !head_killed && (!head_div || div_free);

`ifdef MULQ_BYPASS_EN
  assign bypass = (count == '0) && bus.in_valid && !commit_kill_0[bus.in_rd] &&
                  (bus.in_control[5] || bus.in_control[0] || div_free);
`else
  assign bypass = 1'b0;
`endif

  assign issue = head_ok | bypass;
  // A killed head leaves the queue without reaching the unit.
  assign pop   = head_ok | (head_valid && head_killed);
  assign ready = !count[LNDEPTH];
  assign push  = bus.in_valid && ready && !bypass;

  always_comb begin
    issue_op = head_op;
    if (bypass) issue_op = in_op;
  end

  assign bus.in_ready = ready;
  assign bus.enable   = issue;
  assign bus.control  = issue_op.control;
  assign bus.rd       = issue_op.rd;
  assign bus.makes_rd = issue_op.makes_rd;
  assign bus.hart     = issue_op.hart;
  assign bus.r1       = r1_q;
  assign bus.r2       = r2_q;
  assign empty        = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      valid    <= '0;
      dead     <= '0;
      div_hold <= 1'b0;
      r1_q     <= '0;
      r2_q     <= '0;
    end else begin
      div_hold <= issue && !issue_op.control[5] && !issue_op.control[0];
      if (issue) begin
        r1_q <= issue_op.r1;
        r2_q <= issue_op.r2;
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (valid[i] && commit_kill_0[ops[i].rd]) dead[i] <= 1'b1;
      end
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + LNDEPTH'(1);
      end
      if (push) begin
        valid[tail] <= 1'b1;
        dead[tail]  <= commit_kill_0[bus.in_rd];
        tail        <= tail + LNDEPTH'(1);
      end
      count <= count + (LNDEPTH+1)'(push) - (LNDEPTH+1)'(pop);
    end
  end

  // NOTE: payload storage has no reset; valid bits alone decide whether a slot means anything.
  always_ff @(posedge clk) begin
    if (push) ops[tail] <= in_op;
  end
endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed bench for mul_issue_queue: a queue-level reference model checked every cycle,
// plus hand-computed expectations for each scenario. Honours MULQ_BYPASS_EN like the RTL.
module tb_mul_issue_queue;
  localparam logic [6:0] MUL   = 7'b0000001;
  localparam logic [6:0] CLMUL = 7'b0100000;
  localparam logic [6:0] DIV   = 7'b0000000;

  typedef struct packed {
    logic [6:0]  ctl;
    logic [4:0]  rd;
    logic        mrd;
    logic        hart;
    logic [63:0] r1;
    logic [63:0] r2;
    logic        dead;
  } mop_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] commit_kill_0 = '0;
  logic        empty;
  int          total = 0;
  int          bad = 0;

  mul_issue_queue_if bus ();

  mul_issue_queue dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus),
    .commit_kill_0 (commit_kill_0),
    .empty         (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [6:0] c, input logic [4:0] r, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid    = 1'b1;
    bus.in_control  = c;
    bus.in_rd       = r;
    bus.in_makes_rd = 1'b1;
    bus.in_r1       = a;
    bus.in_r2       = b;
    bus.in_hart     = 1'b0;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reference model: a queue of ops, a one-cycle divide hold and the operand registers.
  initial begin : model
    mop_t        mq[$];
    mop_t        h, src, inop;
    logic        m_hold;
    logic [63:0] m_r1, m_r2;
    logic [31:0] k;
    logic        rst, iv, busy, exp_en, exp_ready, do_pop, byp, free;
    m_hold = 1'b0;
    m_r1   = '0;
    m_r2   = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      k    = commit_kill_0;
      rst  = reset;
      iv   = bus.in_valid;
      busy = bus.divide_busy;
      inop = '{ctl: bus.in_control, rd: bus.in_rd, mrd: bus.in_makes_rd, hart: bus.in_hart,
               r1: bus.in_r1, r2: bus.in_r2, dead: k[bus.in_rd]};
      free      = !busy && !m_hold;
      exp_en    = 1'b0;
      do_pop    = 1'b0;
      byp       = 1'b0;
      src       = inop;
      exp_ready = mq.size() < 4;
      if (mq.size() > 0) begin
        h = mq[0];
        if (h.dead || k[h.rd]) begin
          do_pop = 1'b1;
        end else if (h.ctl[5] || h.ctl[0] || free) begin
          exp_en = 1'b1;
          do_pop = 1'b1;
          src    = h;
        end
      end
`ifdef MULQ_BYPASS_EN
      else if (iv && !inop.dead && (inop.ctl[5] || inop.ctl[0] || free)) begin
        exp_en = 1'b1;
        byp    = 1'b1;
      end
`endif
      check("m_enable", 64'(bus.enable), 64'(exp_en));
      check("m_empty", 64'(empty), 64'(mq.size() == 0));
      check("m_in_ready", 64'(bus.in_ready), 64'(exp_ready));
      check("m_r1", bus.r1, m_r1);
      check("m_r2", bus.r2, m_r2);
      if (exp_en) begin
        check("m_control", 64'(bus.control), 64'(src.ctl));
        check("m_rd", 64'(bus.rd), 64'(src.rd));
        check("m_makes_rd", 64'(bus.makes_rd), 64'(src.mrd));
        check("m_hart", 64'(bus.hart), 64'(src.hart));
      end
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_hold = 1'b0;
        m_r1   = '0;
        m_r2   = '0;
      end else begin
        if (do_pop) void'(mq.pop_front());
        foreach (mq[i]) if (k[mq[i].rd]) mq[i].dead = 1'b1;
        if (iv && exp_ready && !byp) mq.push_back(inop);
        m_hold = exp_en && !src.ctl[5] && !src.ctl[0];
        if (exp_en) begin
          m_r1 = src.r1;
          m_r2 = src.r2;
        end
      end
    end
  end

  initial begin : stim
    int first, second;
    logic [4:0] second_rd;
    bus.divide_busy = 1'b0;
    bus.in_control  = '0;
    bus.in_rd       = '0;
    bus.in_makes_rd = 1'b0;
    bus.in_r1       = '0;
    bus.in_r2       = '0;
    bus.in_hart     = 1'b0;
    idle();

    // Reset state
    cyc();
    settle();
    check("rst_empty", 64'(empty), 64'd1);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_enable", 64'(bus.enable), 64'd0);
    check("rst_r1", bus.r1, 64'd0);
    cyc();
    reset = 1'b0;

    // Single mul rd=3, operands 7 and 6
    drive(MUL, 5'd3, 64'd7, 64'd6);
    settle();
`ifdef MULQ_BYPASS_EN
    check("mul_bypass_en", 64'(bus.enable), 64'd1);
    check("mul_bypass_rd", 64'(bus.rd), 64'd3);
    cyc();
    idle();
    settle();
`else
    check("mul_no_zero_lat", 64'(bus.enable), 64'd0);
    cyc();
    idle();
    settle();
    check("mul_en", 64'(bus.enable), 64'd1);
    check("mul_rd", 64'(bus.rd), 64'd3);
    cyc();
    settle();
`endif
    check("mul_r1", bus.r1, 64'd7);
    check("mul_r2", bus.r2, 64'd6);
    check("mul_empty_after", 64'(empty), 64'd1);
    cyc();

    // Two back-to-back divides; busy rises the cycle after the first issue for 20 cycles
    first = -1;
    second = -1;
    second_rd = '0;
    for (int c = 0; c < 40; c++) begin
      if (c == 0) drive(DIV, 5'd1, 64'd100, 64'd5);
      else if (c == 1) drive(DIV, 5'd2, 64'd200, 64'd7);
      else idle();
      bus.divide_busy = (first >= 0) && (c > first) && (c <= first + 20);
      settle();
      if (bus.enable) begin
        if (first < 0) first = c;
        else if (second < 0) begin
          second = c;
          second_rd = bus.rd;
        end
      end
      cyc();
    end
    bus.divide_busy = 1'b0;
    check("div_gap", 64'(second - first), 64'd21);
    check("div_second_rd", 64'(second_rd), 64'd2);

    // Fill to full behind a blocked div, reject while full, accept next cycle (tail wraps)
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.divide_busy = 1'b1;
    drive(DIV, 5'd4, 64'd40, 64'd41);
    cyc();
    drive(CLMUL, 5'd5, 64'd50, 64'd51);
    cyc();
    drive(MUL, 5'd6, 64'd60, 64'd61);
    cyc();
    drive(MUL, 5'd7, 64'd70, 64'd71);
    cyc();
    idle();
    settle();
    check("full_ready", 64'(bus.in_ready), 64'd0);
    check("full_stall", 64'(bus.enable), 64'd0);
    cyc();
    bus.divide_busy = 1'b0;
    drive(MUL, 5'd9, 64'd99, 64'd98);
    settle();
    check("full_pop_en", 64'(bus.enable), 64'd1);
    check("full_pop_rd", 64'(bus.rd), 64'd4);
    check("full_pop_ready", 64'(bus.in_ready), 64'd0);
    cyc();
    settle();
    check("after_pop_ready", 64'(bus.in_ready), 64'd1);
    check("clmul_in_hold_rd", 64'(bus.rd), 64'd5);
    check("clmul_in_hold_en", 64'(bus.enable), 64'd1);
    cyc();
    idle();
    settle();
    check("order_rd6", 64'(bus.rd), 64'd6);
    cyc();
    settle();
    check("order_rd7", 64'(bus.rd), 64'd7);
    cyc();
    settle();
    check("wrapped_rd9", 64'(bus.rd), 64'd9);
    cyc();
    settle();
    check("full_drained", 64'(empty), 64'd1);
    cyc();

    // Killed entry drained with enable low, next op issues
    drive(MUL, 5'd5, 64'd55, 64'd56);
    commit_kill_0 = 32'h0000_0020;
    settle();
    check("kill_enq_en", 64'(bus.enable), 64'd0);
    cyc();
    commit_kill_0 = '0;
    drive(MUL, 5'd6, 64'd66, 64'd67);
    settle();
    check("kill_drain_en", 64'(bus.enable), 64'd0);
    check("kill_drain_empty", 64'(empty), 64'd0);
    cyc();
    idle();
    settle();
    check("kill_next_en", 64'(bus.enable), 64'd1);
    check("kill_next_rd", 64'(bus.rd), 64'd6);
    check("kill_r1_kept", bus.r1, 64'd99);
    cyc();
    settle();
    check("kill_next_r1", bus.r1, 64'd66);
    cyc();

    // Blocked div at head keeps the younger mul waiting
    bus.divide_busy = 1'b1;
    drive(DIV, 5'd10, 64'd1000, 64'd3);
    cyc();
    drive(MUL, 5'd11, 64'd11, 64'd12);
    settle();
    check("div_block_en0", 64'(bus.enable), 64'd0);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      check("div_block_stall", 64'(bus.enable), 64'd0);
      cyc();
    end
    bus.divide_busy = 1'b0;
    settle();
    check("div_release_rd", 64'(bus.rd), 64'd10);
    check("div_release_en", 64'(bus.enable), 64'd1);
    cyc();
    settle();
    check("mul_after_div_rd", 64'(bus.rd), 64'd11);
    check("mul_after_div_en", 64'(bus.enable), 64'd1);
    cyc();

    // Reset with three valid entries and r1 holding 0x1234
    drive(MUL, 5'd1, 64'h1234, 64'h5678);
    cyc();
    bus.divide_busy = 1'b1;
    drive(DIV, 5'd2, 64'd20, 64'd21);
    cyc();
    drive(MUL, 5'd3, 64'd30, 64'd31);
    cyc();
    drive(MUL, 5'd4, 64'd40, 64'd41);
    cyc();
    idle();
    settle();
    check("pre_rst_r1", bus.r1, 64'h1234);
    check("pre_rst_empty", 64'(empty), 64'd0);
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    bus.divide_busy = 1'b0;
    settle();
    check("mid_rst_empty", 64'(empty), 64'd1);
    check("mid_rst_enable", 64'(bus.enable), 64'd0);
    check("mid_rst_r1", bus.r1, 64'd0);
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mul_issue_queue.md
Name: mul_issue_queue

Overview:
- In-order issue queue directly upstream of the multiply/divide unit.
- Buffers mul/div/clmul micro-ops from rename/dispatch and presents them on the unit's enable/control/rd/makes_rd/hart inputs.
- Supplies r1/r2 one cycle after issue, because the unit samples operands in the cycle after enable.
- Serialises divides against the unit's single iterative divider.
- Drops entries killed by commit_kill_0 before or at issue.

Parameters:
- CNTRL_SIZE, 7, width of control field (bit5 bopt, bit4 addw, bit3 inv, bits2:1 sgn, bit0 mul)
- RV, 64, operand width
- NHART, 1, number of harts
- LNHART, 0, log2(NHART)
- NCOMMIT, 32, commit registers
- LNCOMMIT, 5, log2(NCOMMIT)
- DEPTH, 4, queue entries (power of 2)
- LNDEPTH, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  dispatch offers an op
- in_ready  out  1  queue accepts op (count<DEPTH)
- in_control  in  CNTRL_SIZE  op control
- in_rd  in  LNCOMMIT  destination commit reg
- in_makes_rd  in  1  op writes rd
- in_r1, in_r2  in  RV  operands
- in_hart  in  (NHART==1?1:LNHART)  hart
- commit_kill_0  in  NCOMMIT  kill vector
- divide_busy  in  1  divider busy, from unit
- enable  out  1  issue strobe to unit
- control  out  CNTRL_SIZE
- rd  out  LNCOMMIT
- makes_rd  out  1
- hart  out  (NHART==1?1:LNHART)
- r1, r2  out  RV  registered operands of the op issued last cycle
- empty  out  1  no valid entries

Behaviour:
- Reset: all entries invalid, head/tail/count=0, enable=0, r1=r2=0, div_hold=0, empty=1, in_ready=1.
- Circular FIFO. head/tail are LNDEPTH bits and wrap DEPTH-1 -> 0. count is LNDEPTH+1 bits.
- Enqueue when in_valid && in_ready. in_ready gives no same-cycle pop credit; it is 0 when full even if the head issues.
- Each entry holds control, rd, makes_rd, hart, r1, r2, and a dead bit.
- Enqueue with commit_kill_0[in_rd]=1 stores the entry with dead=1.
- Each cycle, every valid entry whose commit_kill_0[rd] is set gets dead<=1.
- Div op: control[5]==0 && control[0]==0. All other ops are non-div.
- Issue condition, combinational:
  - head valid, !dead, !commit_kill_0[head.rd], and
  - (non-div) or (div && !divide_busy && !div_hold).
- On issue:
  - enable=1 and control/rd/makes_rd/hart driven from head.
  - head is popped.
  - Next cycle r1/r2 <= head operands, held until the next issue.
- div_hold: set for exactly one cycle after a div issue. This covers the cycle before divide_busy rises. A second div is never issued back-to-back.
- Head valid but dead (or killed this cycle): popped with enable=0, one entry per cycle, r1/r2 unchanged.
- Head is a blocked div: stall. Younger ops do not bypass (strict in-order).
- Simultaneous enqueue+pop: count unchanged. Enqueue into empty queue: issue no earlier than the next cycle.
- Reset mid-operation: all entries and div_hold cleared next edge. An in-flight r1/r2 is overwritten to 0.
- When not issuing, enable=0 and control/rd/makes_rd/hart are don't-care.

Optional Feature:
- MULQ_BYPASS_EN defined: when the queue is empty (or only dead entries at head are being drained is excluded — must be truly empty) and in_valid, an op meeting the issue condition (kill checked on in_rd) issues in the same cycle without being written. r1/r2 <= in_r1/in_r2 next cycle. Minimum latency is 0 cycles.
- Undefined: every op spends at least one cycle in the queue.

Test Plan:
- Reset, then enqueue mul rd=3, r1=7, r2=6 -> enable=1 with rd=3 one cycle later (zero-cycle when bypass on); r1=7, r2=6 the following cycle; empty=1 after.
- Two divs back-to-back, divide_busy rising the cycle after the first issue and held 20 cycles -> second div enable not before the cycle after divide_busy falls; never issued in consecutive cycles.
- Fill 4 entries -> in_ready=0. Pop one and enqueue the same cycle -> rejected. Enqueue the next cycle -> accepted; tail wraps 3 -> 0.
- Enqueue rd=5, then assert commit_kill_0[5] before issue -> entry drained with enable=0, following op rd=6 issues next cycle.
- Div at head blocked by divide_busy=1, mul behind it -> mul does not issue until the div issues.
- Assert reset while 3 entries are valid and r1=0x1234 -> next cycle empty=1, enable=0, r1=0.
